// File: rtl/calc_input_sequencer.sv
// Calculator front-end: synchronises and debounces ENTER/UNDO, then walks operand A -> B -> opcode -> show,
// issuing one-cycle load enables with a registered copy of the switches.
module calc_input_sequencer #(
    parameter int unsigned DATA_W          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_enter,
    input  logic              btn_undo,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] data_out,
    output logic              load_a,
    output logic              load_b,
    output logic              load_op,
    output logic              result_valid,
    output logic [3:0]        state_onehot
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned NBTN  = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Button index 0 is ENTER, index 1 is UNDO.
    logic [NBTN-1:0]            btn_raw;
    logic [NBTN-1:0]            s1_q, s1_d;
    logic [NBTN-1:0]            s2_q, s2_d;
    logic [NBTN-1:0]            stable_q, stable_d;
    logic [NBTN-1:0]            stable_dly_q, stable_dly_d;
    logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NBTN-1:0]            press_c;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              load_a_q, load_a_d;
    logic              load_b_q, load_b_d;
    logic              load_op_q, load_op_d;
    logic              result_valid_q, result_valid_d;
    logic [3:0]        state_onehot_q, state_onehot_d;

    assign btn_raw = {btn_undo, btn_enter};

    // Debounce: a level must differ from the stable value for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        s1_d         = btn_raw;
        s2_d         = s1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        cnt_d        = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_c = stable_q & ~stable_dly_q;

    // Sequencer next state; undo takes priority over a simultaneous enter.
    always_comb begin
        state_d        = state_q;
        data_out_d     = data_out_q;
        load_a_d       = 1'b0;
        load_b_d       = 1'b0;
        load_op_d      = 1'b0;
        if (press_c[1]) begin
            case (state_q)
                S_A:    state_d = S_A;
                S_B:    state_d = S_A;
                S_OP:   state_d = S_B;
                S_SHOW: state_d = S_OP;
            endcase
        end else if (press_c[0]) begin
            case (state_q)
                S_A: begin
                    load_a_d   = 1'b1;
                    data_out_d = sw_in;
                    state_d    = S_B;
                end
                S_B: begin
                    load_b_d   = 1'b1;
                    data_out_d = sw_in;
                    state_d    = S_OP;
                end
                S_OP: begin
                    load_op_d  = 1'b1;
                    data_out_d = sw_in;
                    state_d    = S_SHOW;
                end
                S_SHOW: state_d = S_A;
            endcase
        end
        case (state_d)
            S_A:    state_onehot_d = 4'b0001;
            S_B:    state_onehot_d = 4'b0010;
            S_OP:   state_onehot_d = 4'b0100;
            S_SHOW: state_onehot_d = 4'b1000;
        endcase
        result_valid_d = (state_d == S_SHOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            stable_q       <= '0;
            stable_dly_q   <= '0;
            cnt_q          <= '0;
            state_q        <= S_A;
            data_out_q     <= '0;
            load_a_q       <= 1'b0;
            load_b_q       <= 1'b0;
            load_op_q      <= 1'b0;
            result_valid_q <= 1'b0;
            state_onehot_q <= 4'b0001;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            stable_q       <= stable_d;
            stable_dly_q   <= stable_dly_d;
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            data_out_q     <= data_out_d;
            load_a_q       <= load_a_d;
            load_b_q       <= load_b_d;
            load_op_q      <= load_op_d;
            result_valid_q <= result_valid_d;
            state_onehot_q <= state_onehot_d;
        end
    end

    assign data_out     = data_out_q;
    assign load_a       = load_a_q;
    assign load_b       = load_b_q;
    assign load_op      = load_op_q;
    assign result_valid = result_valid_q;
    assign state_onehot = state_onehot_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: constant vector table, hand-written corner sequences and
// randomized button activity checked every cycle against a history-based reference model.
module tb_calc_input_sequencer;

    localparam int unsigned DW = 5;
    localparam int unsigned DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_enter;
    logic          btn_undo;
    logic [DW-1:0] sw_in;
    logic [DW-1:0] data_out;
    logic          load_a, load_b, load_op, result_valid;
    logic [3:0]    state_onehot;

    always #5 clk = ~clk;

    calc_input_sequencer #(.DATA_W(DW), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_undo(btn_undo), .sw_in(sw_in),
        .data_out(data_out), .load_a(load_a), .load_b(load_b), .load_op(load_op),
        .result_valid(result_valid), .state_onehot(state_onehot)
    );

    int total = 0;
    int bad   = 0;
    int la, lb, lo;
    bit chk_en = 1'b0;

    // Reference model: a button level is accepted once the last DC synchronised samples all disagree.
    logic [1:0]    m_pipe [2];
    logic [DC-1:0] m_hist [2];
    int            m_nh   [2];
    logic          m_st   [2];
    logic          m_st_old [2];
    int            m_state;
    logic [2:0]    m_load;
    logic [DW-1:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [1:0] raw;
        logic [1:0] prs;
        logic       lvl;
        raw = {btn_undo, btn_enter};
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_pipe[b] = '0; m_hist[b] = '0; m_nh[b] = 0; m_st[b] = 1'b0; m_st_old[b] = 1'b0;
            end
            m_state = 0;
            m_load  = '0;
            m_data  = '0;
        end else begin
            prs = '0;
            for (int b = 0; b < 2; b++) begin
                lvl       = m_pipe[b][1];
                m_pipe[b] = {m_pipe[b][0], raw[b]};
                m_hist[b] = {m_hist[b][DC-2:0], lvl};
                if (m_nh[b] < int'(DC)) m_nh[b]++;
                prs[b]      = m_st[b] & ~m_st_old[b];
                m_st_old[b] = m_st[b];
                if (m_nh[b] >= int'(DC) && m_hist[b] == {DC{~m_st[b]}}) begin
                    m_st[b] = lvl;
                    m_nh[b] = 0;
                end
            end
            m_load = '0;
            if (prs[1]) begin
                if (m_state > 0) m_state--;
            end else if (prs[0]) begin
                if (m_state < 3) begin
                    m_load[m_state] = 1'b1;
                    m_data          = sw_in;
                end
                m_state = (m_state + 1) % 4;
            end
        end
    endtask

    // One clock: model follows the posedge, outputs are sampled on the following negedge.
    task automatic cyc();
        logic [3:0] exp_oh;
        @(posedge clk);
        model_step();
        @(negedge clk);
        la += int'(load_a);
        lb += int'(load_b);
        lo += int'(load_op);
        if (chk_en) begin
            exp_oh = 4'(1 << m_state);
            check("m_loads", 32'({load_op, load_b, load_a}), 32'(m_load));
            check("m_data", 32'(data_out), 32'(m_data));
            check("m_onehot", 32'(state_onehot), 32'(exp_oh));
            check("m_valid", 32'(result_valid), 32'(m_state == 3));
        end
    endtask

    task automatic press(input logic e, input logic u);
        btn_enter = e;
        btn_undo  = u;
        repeat (8) cyc();
        btn_enter = 1'b0;
        btn_undo  = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_enter = 1'b0;
        btn_undo  = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic          ent;
        logic          und;
        logic [DW-1:0] sw;
        int            cyc;
        logic [3:0]    oh;
        logic [DW-1:0] data;
        logic          rv;
        logic [2:0]    loads;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 5'h00, 2,  4'b0001, 5'h00, 1'b0, 3'b000};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 5'h03, 10, 4'b0010, 5'h03, 1'b0, 3'b001};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 5'h03, 8,  4'b0010, 5'h03, 1'b0, 3'b000};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 5'h00, 2,  4'b0001, 5'h00, 1'b0, 3'b000};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 5'h07, 8,  4'b0010, 5'h07, 1'b0, 3'b001};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 5'h07, 8,  4'b0010, 5'h07, 1'b0, 3'b000};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 5'h02, 8,  4'b0100, 5'h02, 1'b0, 3'b010};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 5'h02, 8,  4'b0100, 5'h02, 1'b0, 3'b000};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 5'h01, 8,  4'b1000, 5'h01, 1'b1, 3'b100};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 5'h01, 8,  4'b1000, 5'h01, 1'b1, 3'b000};
        vt[10] = '{1'b0, 1'b1, 1'b0, 5'h1F, 8,  4'b0001, 5'h01, 1'b0, 3'b000};
        vt[11] = '{1'b0, 1'b0, 1'b0, 5'h1F, 8,  4'b0001, 5'h01, 1'b0, 3'b000};

        rst = 1'b1; btn_enter = 1'b0; btn_undo = 1'b0; sw_in = '0;
        la = 0; lb = 0; lo = 0;
        cyc();
        chk_en = 1'b1;

        // Table-driven segments: reset, first load, full sequence and wrap-around press.
        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; btn_enter = vt[i].ent; btn_undo = vt[i].und; sw_in = vt[i].sw;
            la = 0; lb = 0; lo = 0;
            repeat (vt[i].cyc) cyc();
            check($sformatf("v%0d_onehot", i), 32'(state_onehot), 32'(vt[i].oh));
            check($sformatf("v%0d_data", i), 32'(data_out), 32'(vt[i].data));
            check($sformatf("v%0d_valid", i), 32'(result_valid), 32'(vt[i].rv));
            check($sformatf("v%0d_na", i), 32'(la), 32'(vt[i].loads[0]));
            check($sformatf("v%0d_nb", i), 32'(lb), 32'(vt[i].loads[1]));
            check($sformatf("v%0d_nop", i), 32'(lo), 32'(vt[i].loads[2]));
        end

        // Bounced enter: 1,1,1,0,1,1 then low never reaches the debounce threshold.
        begin
            logic [5:0] pat;
            pat = 6'b110111;
            do_reset();
            la = 0; lb = 0; lo = 0;
            for (int i = 0; i < 6; i++) begin
                btn_enter = pat[i];
                cyc();
            end
            btn_enter = 1'b0;
            repeat (12) cyc();
            check("bounce_loads", 32'(la + lb + lo), 32'd0);
            check("bounce_onehot", 32'(state_onehot), 32'b0001);
        end

        // Undo from S_OP, then simultaneous enter+undo where undo must win.
        do_reset();
        sw_in = 5'h0A; press(1'b1, 1'b0);
        sw_in = 5'h0B; press(1'b1, 1'b0);
        check("undo_pre_onehot", 32'(state_onehot), 32'b0100);
        sw_in = 5'h1C;
        la = 0; lb = 0; lo = 0;
        press(1'b0, 1'b1);
        check("undo_onehot", 32'(state_onehot), 32'b0010);
        check("undo_loads", 32'(la + lb + lo), 32'd0);
        press(1'b1, 1'b1);
        check("both_onehot", 32'(state_onehot), 32'b0001);
        check("both_loads", 32'(la + lb + lo), 32'd0);
        check("both_data", 32'(data_out), 32'h0B);

        // Reset mid-debounce with enter held: load_a exactly 6 edges after reset falls.
        do_reset();
        sw_in = 5'h15;
        btn_enter = 1'b1;
        repeat (4) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("rst_hold_load_a_%0d", i), 32'(load_a), 32'(i == 6));
        end
        check("rst_hold_data", 32'(data_out), 32'h15);
        btn_enter = 1'b0;
        repeat (8) cyc();

        // Randomized button activity with occasional resets.
        for (int s = 0; s < 300; s++) begin
            rst       = ($urandom_range(0, 49) == 0);
            btn_enter = 1'($urandom_range(0, 1));
            btn_undo  = ($urandom_range(0, 3) == 0);
            sw_in     = DW'($urandom);
            if (rst) begin
                cyc();
                rst = 1'b0;
            end else begin
                repeat ($urandom_range(1, 9)) cyc();
            end
        end
        rst = 1'b0; btn_enter = 1'b0; btn_undo = 1'b0;
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
